// File: rtl/lzw_forward_compress_if.sv
`default_nettype none
// ============================================================================
// Module      : lzw_forward_compress_if
// Description : Bundles the payload input handshake, the compressed-code
//               output, the dictionary-sync write bus and the statistic
//               counters of the LZW forward compressor.
//               master : payload source / link side (drives I_*)
//               slave  : the compressor (drives O_*)
// Revision    : 1.0  initial release
// ============================================================================
interface lzw_forward_compress_if;
  logic        I_state_clr;
  logic [7:0]  I_payload_data;
  logic        I_payload_data_en;
  logic        I_payload_last;
  logic        O_payload_ready;
  logic [13:0] O_compress_data;
  logic        O_compress_data_en;
  logic [22:0] O_dictionary_sync_data;
  logic [13:0] O_dictionary_sync_addr;
  logic        O_dictionary_sync_wren;
  logic [31:0] O_byte_cnt;
  logic [31:0] O_code_cnt;

  modport master (
    output I_state_clr, I_payload_data, I_payload_data_en, I_payload_last,
    input  O_payload_ready, O_compress_data, O_compress_data_en,
           O_dictionary_sync_data, O_dictionary_sync_addr,
           O_dictionary_sync_wren, O_byte_cnt, O_code_cnt
  );

  modport slave (
    input  I_state_clr, I_payload_data, I_payload_data_en, I_payload_last,
    output O_payload_ready, O_compress_data, O_compress_data_en,
           O_dictionary_sync_data, O_dictionary_sync_addr,
           O_dictionary_sync_wren, O_byte_cnt, O_code_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lzw_forward_compress.sv
`default_nettype none
// ============================================================================
// Module      : lzw_forward_compress
// Description : Transmit-side LZW compressor with a hashed forward
//               dictionary (16384 x 37 RAM). Emits 14-bit codes and, for
//               each new dictionary entry, a sync write so the receiver can
//               rebuild the same dictionary.
// Ports       : I_sys_clk  - system clock
//               I_sys_rst  - synchronous active-high reset
//               bus        - slave side of lzw_forward_compress_if
//                            (payload in, codes out, sync bus, counters)
// Revision    : 1.0  initial release
// ============================================================================
module lzw_forward_compress (
  input  logic                  I_sys_clk,
  input  logic                  I_sys_rst,
  lzw_forward_compress_if.slave bus
);

  localparam logic [2:0]  ST_INIT   = 3'd0;
  localparam logic [2:0]  ST_EMPTY  = 3'd1;
  localparam logic [2:0]  ST_ACTIVE = 3'd2;
  localparam logic [2:0]  ST_CMP    = 3'd3;
  localparam logic [2:0]  ST_FLUSH  = 3'd4;
  localparam logic [13:0] FIRST_DICT_CODE = 14'd256;
  localparam logic [13:0] LAST_INDEX      = 14'h3FFF;

  // Entry layout: {valid, prefix[13:0], byte[7:0], code[13:0]}
  logic [36:0] dict_mem [0:16383];
  logic [36:0] rd_q;

  logic [2:0]  state;
  logic        ready;
  logic [13:0] init_addr;
  logic [13:0] cur_code;
  logic [13:0] next_code;
  logic        dict_full;
  logic [7:0]  byte_q;
  logic        last_q;
  logic [13:0] hash_q;

  logic [13:0] code_q;
  logic        code_en_q;
  logic [22:0] sync_data_q;
  logic [13:0] sync_addr_q;
  logic        sync_wren_q;
  logic [31:0] byte_cnt;
  logic [31:0] code_cnt;

  logic        accept;
  logic        rd_en;
  logic [13:0] hash;
  logic        rd_valid;
  logic        hit;
  logic        emit;
  logic [13:0] emit_code;
  logic        insert;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [36:0] wr_data;

  assign accept   = bus.I_payload_data_en & ready;
  assign rd_en    = accept & (state == ST_ACTIVE);
  assign hash     = cur_code ^ {bus.I_payload_data, 6'h00};
  assign rd_valid = rd_q[36];
  assign hit      = rd_valid && (rd_q[35:22] == cur_code) && (rd_q[21:14] == byte_q);

  always_comb begin
    emit      = 1'b0;
    emit_code = cur_code;
    insert    = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = init_addr;
    wr_data   = '0;
    case (state)
      ST_INIT: begin
        wr_en = 1'b1;
      end
      ST_EMPTY: begin
        if (accept && bus.I_payload_last) begin
          emit      = 1'b1;
          emit_code = {6'h00, bus.I_payload_data};
        end
      end
      ST_CMP: begin
        if (hit) begin
          emit      = last_q;
          emit_code = rd_q[13:0];
        end else begin
          emit = 1'b1;
          // Only an empty slot takes a new entry; a collision keeps the resident.
          insert  = !rd_valid && !dict_full;
          wr_en   = insert;
          wr_addr = hash_q;
          wr_data = {1'b1, cur_code, byte_q, next_code};
        end
      end
      ST_FLUSH: begin
        emit = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_sys_clk) begin
    if (wr_en) dict_mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= dict_mem[hash];
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) begin
      state       <= ST_INIT;
      ready       <= 1'b0;
      init_addr   <= '0;
      cur_code    <= '0;
      next_code   <= FIRST_DICT_CODE;
      dict_full   <= 1'b0;
      byte_q      <= '0;
      last_q      <= 1'b0;
      hash_q      <= '0;
      code_q      <= '0;
      code_en_q   <= 1'b0;
      sync_data_q <= '0;
      sync_addr_q <= '0;
      sync_wren_q <= 1'b0;
    end else begin
      code_en_q   <= emit;
      sync_wren_q <= insert;
      if (emit) code_q <= emit_code;
      if (insert) begin
        sync_addr_q <= next_code;
        sync_data_q <= {1'b1, cur_code, byte_q};
        if (next_code == LAST_INDEX) dict_full <= 1'b1;
        else                         next_code <= next_code + 14'd1;
      end
      case (state)
        ST_INIT: begin
          init_addr <= init_addr + 14'd1;
          if (init_addr == LAST_INDEX) begin
            state <= ST_EMPTY;
            ready <= 1'b1;
          end
        end
        ST_EMPTY: begin
          if (accept) begin
            cur_code <= {6'h00, bus.I_payload_data};
            if (!bus.I_payload_last) state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (accept) begin
            byte_q <= bus.I_payload_data;
            last_q <= bus.I_payload_last;
            hash_q <= hash;
            state  <= ST_CMP;
            ready  <= 1'b0;
          end
        end
        ST_CMP: begin
          if (hit) begin
            cur_code <= rd_q[13:0];
            state    <= last_q ? ST_EMPTY : ST_ACTIVE;
            ready    <= 1'b1;
          end else begin
            cur_code <= {6'h00, byte_q};
            state    <= last_q ? ST_FLUSH : ST_ACTIVE;
            ready    <= !last_q;
          end
        end
        ST_FLUSH: begin
          state <= ST_EMPTY;
          ready <= 1'b1;
        end
        default: begin
          state <= ST_INIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Statistic counters; a clear wins over an increment in the same cycle.
  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst || bus.I_state_clr) begin
      byte_cnt <= '0;
      code_cnt <= '0;
    end else begin
      if (accept) byte_cnt <= byte_cnt + 32'd1;
      if (emit)   code_cnt <= code_cnt + 32'd1;
    end
  end

  assign bus.O_payload_ready        = ready;
  assign bus.O_compress_data        = code_q;
  assign bus.O_compress_data_en     = code_en_q;
  assign bus.O_dictionary_sync_data = sync_data_q;
  assign bus.O_dictionary_sync_addr = sync_addr_q;
  assign bus.O_dictionary_sync_wren = sync_wren_q;
  assign bus.O_byte_cnt             = byte_cnt;
  assign bus.O_code_cnt             = code_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lzw_forward_compress.sv
`default_nettype none
// ============================================================================
// Module      : tb_lzw_forward_compress
// Description : Self-checking bench for lzw_forward_compress. A string-level
//               LZW model predicts the code and sync-write streams; a
//               compare process checks every output strobe against it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lzw_forward_compress;

  logic clk = 1'b0;
  logic rst;
  always #2 clk = ~clk;

  lzw_forward_compress_if ifc ();

  lzw_forward_compress dut (
    .I_sys_clk (clk),
    .I_sys_rst (rst),
    .bus       (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [16384];
  logic [13:0] m_pre   [16384];
  logic [7:0]  m_byt   [16384];
  logic [13:0] m_code  [16384];
  logic [13:0] m_next;
  bit          m_full;
  bit          m_in_frame;
  logic [13:0] m_cur;
  logic [13:0] exp_codes [$];
  logic [36:0] exp_sync  [$];

  task automatic model_reset();
    for (int i = 0; i < 16384; i++) m_valid[i] = 1'b0;
    m_next = 14'd256; m_full = 1'b0; m_in_frame = 1'b0; m_cur = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit last);
    logic [13:0] h;
    if (!m_in_frame) begin
      m_cur = {6'h00, b};
      if (last) exp_codes.push_back(m_cur);
      else      m_in_frame = 1'b1;
    end else begin
      h = m_cur ^ {b, 6'h00};
      if (m_valid[h] && m_pre[h] == m_cur && m_byt[h] == b) begin
        m_cur = m_code[h];
        if (last) begin exp_codes.push_back(m_cur); m_in_frame = 1'b0; end
      end else begin
        exp_codes.push_back(m_cur);
        if (!m_valid[h] && !m_full) begin
          m_valid[h] = 1'b1; m_pre[h] = m_cur; m_byt[h] = b; m_code[h] = m_next;
          exp_sync.push_back({m_next, 1'b1, m_cur, b});
          if (m_next == 14'h3FFF) m_full = 1'b1;
          else                    m_next = m_next + 14'd1;
        end
        m_cur = {6'h00, b};
        if (last) begin exp_codes.push_back(m_cur); m_in_frame = 1'b0; end
      end
    end
  endtask

  // ---------------- compare process ----------------
  logic [13:0] log_code [$];
  int          log_cyc  [$];
  logic [36:0] log_sync [$];
  int          sync_total = 0;
  logic [13:0] last_sync_addr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.O_compress_data_en) begin
        log_code.push_back(ifc.O_compress_data);
        log_cyc.push_back(cyc);
        if (exp_codes.size() == 0) chk("unexpected_code", {50'h0, ifc.O_compress_data}, 64'hFFFF);
        else chk("code", {50'h0, ifc.O_compress_data}, {50'h0, exp_codes.pop_front()});
      end
      if (ifc.O_dictionary_sync_wren) begin
        sync_total++;
        last_sync_addr = ifc.O_dictionary_sync_addr;
        log_sync.push_back({ifc.O_dictionary_sync_addr, ifc.O_dictionary_sync_data});
        if (exp_sync.size() == 0)
          chk("unexpected_sync", {27'h0, ifc.O_dictionary_sync_addr, ifc.O_dictionary_sync_data}, 64'hFFFF_FFFF_FFFF);
        else
          chk("sync", {27'h0, ifc.O_dictionary_sync_addr, ifc.O_dictionary_sync_data}, {27'h0, exp_sync.pop_front()});
        chk("sync_with_code", {63'h0, ifc.O_compress_data_en}, 64'h1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n = 0;
    ifc.I_payload_data = b; ifc.I_payload_last = last; ifc.I_payload_data_en = 1'b1;
    while (ifc.O_payload_ready !== 1'b1) begin
      if (n >= 64) begin
        chk("ready_timeout", 64'h0, 64'h1);
        ifc.I_payload_data_en = 1'b0; ifc.I_payload_last = 1'b0;
        return;
      end
      @(negedge clk); n++;
    end
    model_byte(b, last);
    @(negedge clk);
    ifc.I_payload_data_en = 1'b0; ifc.I_payload_last = 1'b0;
  endtask

  task automatic send_frame_a();
    logic [7:0] fa [7] = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61, 8'h62, 8'h61};
    for (int i = 0; i < 7; i++) send_byte(fa[i], i == 6);
  endtask

  task automatic clear_logs();
    log_code.delete(); log_cyc.delete(); log_sync.delete();
  endtask

  task automatic wait_init_done();
    int n = 0;
    while (ifc.O_payload_ready !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    chk("init_done", {63'h0, ifc.O_payload_ready}, 64'h1);
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] y;
    int start = $urandom_range(0, 255);
    if (!m_in_frame) return 8'($urandom);
    for (int k = 0; k < 256; k++) begin
      y = 8'(start + k);
      if (!m_valid[m_cur ^ {y, 6'h00}]) return y;
    end
    return 8'($urandom);
  endfunction

  logic [13:0] run1_codes [$];

  initial begin
    int zero_cnt;
    bit init_bad;
    int nbytes;
    model_reset();
    ifc.I_state_clr = 1'b0; ifc.I_payload_data = '0;
    ifc.I_payload_data_en = 1'b0; ifc.I_payload_last = 1'b0;
    rst = 1'b1;
    idle(4);
    chk("reset_outputs", {ifc.O_payload_ready, ifc.O_compress_data_en, ifc.O_dictionary_sync_wren,
         ifc.O_compress_data, ifc.O_dictionary_sync_addr, 27'h0} | {32'h0, ifc.O_byte_cnt | ifc.O_code_cnt}
         | {41'h0, ifc.O_dictionary_sync_data}, 64'h0);
    rst = 1'b0;

    // INIT length and quiet outputs
    zero_cnt = 0; init_bad = 1'b0;
    while (ifc.O_payload_ready !== 1'b1 && zero_cnt < 20000) begin
      if (ifc.O_compress_data_en || ifc.O_dictionary_sync_wren || ifc.O_compress_data != 0 ||
          ifc.O_dictionary_sync_data != 0 || ifc.O_dictionary_sync_addr != 0 ||
          ifc.O_byte_cnt != 0 || ifc.O_code_cnt != 0) init_bad = 1'b1;
      zero_cnt++;
      @(negedge clk);
    end
    chk("init_cycles", 64'(zero_cnt), 64'd16384);
    chk("init_outputs_zero", {63'h0, init_bad}, 64'h0);

    // Frame A with literal expectations
    clear_logs();
    send_frame_a();
    idle(6);
    chk("a_ncodes", 64'(log_code.size()), 64'd4);
    if (log_code.size() == 4) begin
      chk("a_code0", {50'h0, log_code[0]}, 64'h061);
      chk("a_code1", {50'h0, log_code[1]}, 64'h062);
      chk("a_code2", {50'h0, log_code[2]}, 64'h100);
      chk("a_code3", {50'h0, log_code[3]}, 64'h102);
    end
    chk("a_nsync", 64'(log_sync.size()), 64'd3);
    if (log_sync.size() == 3) begin
      chk("a_sync0", {27'h0, log_sync[0]}, {27'h0, 14'd256, 23'h406162});
      chk("a_sync1", {27'h0, log_sync[1]}, {27'h0, 14'd257, 23'h406261});
      chk("a_sync2", {27'h0, log_sync[2]}, {27'h0, 14'd258, 23'h410061});
    end
    chk("a_byte_cnt", {32'h0, ifc.O_byte_cnt}, 64'd7);
    chk("a_code_cnt", {32'h0, ifc.O_code_cnt}, 64'd4);
    run1_codes = log_code;

    // Single byte with last in EMPTY
    clear_logs();
    send_byte(8'h41, 1'b1);
    chk("single_ready", {63'h0, ifc.O_payload_ready}, 64'h1);
    idle(4);
    chk("single_ready_hold", {63'h0, ifc.O_payload_ready}, 64'h1);
    chk("single_ncodes", 64'(log_code.size()), 64'd1);
    if (log_code.size() == 1) chk("single_code", {50'h0, log_code[0]}, 64'h041);
    chk("single_nsync", 64'(log_sync.size()), 64'd0);

    // Miss on the last byte: literal then flush on back-to-back cycles
    clear_logs();
    send_byte(8'h63, 1'b0);
    send_byte(8'h64, 1'b1);
    idle(6);
    chk("flush_ncodes", 64'(log_code.size()), 64'd2);
    if (log_code.size() == 2) begin
      chk("flush_code0", {50'h0, log_code[0]}, 64'h063);
      chk("flush_code1", {50'h0, log_code[1]}, 64'h064);
      chk("flush_adjacent", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
    end
    chk("flush_nsync", 64'(log_sync.size()), 64'd1);
    if (log_sync.size() == 1) chk("flush_sync", {27'h0, log_sync[0]}, {27'h0, 14'd259, 23'h406364});

    // Counter clear coincident with a code emission
    ifc.I_state_clr = 1'b1;
    send_byte(8'h41, 1'b1);
    ifc.I_state_clr = 1'b0;
    chk("clr_emit_seen", {63'h0, ifc.O_compress_data_en}, 64'h1);
    chk("clr_byte_cnt", {32'h0, ifc.O_byte_cnt}, 64'd0);
    chk("clr_code_cnt", {32'h0, ifc.O_code_cnt}, 64'd0);
    idle(3);

    // Reset in the middle of a frame
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h61, 1'b0);
    idle(4);
    chk("pre_reset_drained", 64'(exp_codes.size() + exp_sync.size()), 64'd0);
    rst = 1'b1;
    model_reset();
    exp_codes.delete(); exp_sync.delete();
    idle(3);
    sync_total = 0;
    rst = 1'b0;
    wait_init_done();
    clear_logs();
    send_frame_a();
    idle(6);
    chk("rerun_ncodes", 64'(log_code.size()), 64'(run1_codes.size()));
    for (int i = 0; i < log_code.size() && i < run1_codes.size(); i++)
      chk("rerun_code", {50'h0, log_code[i]}, {50'h0, run1_codes[i]});
    chk("rerun_byte_cnt", {32'h0, ifc.O_byte_cnt}, 64'd7);
    chk("rerun_code_cnt", {32'h0, ifc.O_code_cnt}, 64'd4);

    // Dictionary fill with pseudo-random bytes steered toward empty slots
    nbytes = 0;
    while (!m_full && nbytes < 40000) begin
      send_byte(pick_byte(), 1'b0);
      nbytes++;
    end
    chk("fill_reached", {63'h0, m_full}, 64'h1);
    for (int i = 0; i < 200; i++) send_byte(8'($urandom), i == 199);
    idle(8);
    chk("fill_sync_total", 64'(sync_total), 64'd16128);
    chk("fill_last_addr", {50'h0, last_sync_addr}, 64'h3FFF);
    chk("fill_drained", 64'(exp_codes.size() + exp_sync.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lzw_forward_compress.md
# lzw_forward_compress

Transmit-side LZW compressor. It accepts payload bytes and builds the forward dictionary in a hashed lookup RAM. It emits 14-bit compressed codes, and for every new dictionary entry it emits a sync write so the receive-side decompressor rebuilds an identical backward dictionary. It sits between the payload source and the link carrying compressed codes plus the dictionary-sync bus.

## Interface
- No parameters. Widths are fixed: code 14 bits, byte 8 bits, dictionary depth 16384.
- I_sys_clk  in  1  system clock, 250 MHz
- I_sys_rst  in  1  synchronous, active-high reset
- I_state_clr  in  1  clears the statistic counters
- I_payload_data  in  8  payload byte
- I_payload_data_en  in  1  byte valid; the byte is taken only when O_payload_ready=1
- I_payload_last  in  1  last byte of a frame; qualified by I_payload_data_en
- O_payload_ready  out  1  block can accept a byte this cycle
- O_compress_data  out  14  compressed code
- O_compress_data_en  out  1  code valid, single-cycle strobe
- O_dictionary_sync_data  out  23  sync entry: [22]=valid(1), [21:8]=prefix code, [7:0]=appended byte
- O_dictionary_sync_addr  out  14  new code, 256..16383
- O_dictionary_sync_wren  out  1  sync write strobe
- O_byte_cnt  out  32  count of accepted bytes, wraps
- O_code_cnt  out  32  count of emitted codes, wraps

## Operation
- Codes 0..255 are literal bytes. Dictionary codes run from 256 to 16383.
- Internal hash RAM: 16384×37 bits, holding {valid, prefix[13:0], byte[7:0], code[13:0]}. Single write port, one read port, 1-cycle read latency.
- Hash index: h = cur_code ^ {byte, 6'h00}, 14 bits.
- State machine:
  - INIT: sweeps h=0..16383 writing all zeros, one address per cycle. O_payload_ready=0. Moves to EMPTY after address 16383.
  - EMPTY: ready=1. On an accepted byte, cur_code={6'h0, byte}.
    - If last is also asserted, emit cur_code and stay in EMPTY.
    - Otherwise go to ACTIVE.
  - ACTIVE: ready=1. On an accepted byte, latch the byte and last flag, issue a read at h, and go to CMP.
  - CMP: ready=0. Hit means valid && prefix==cur_code && byte==latched byte.
    - Hit: cur_code=stored code. If last, emit cur_code and go to EMPTY; otherwise go to ACTIVE.
    - Miss: emit cur_code.
      - If the slot is invalid and dict_full=0: write {1, cur_code, byte, next_code} to h, issue a sync write (addr=next_code, data={1, cur_code, byte}), then increment next_code.
      - Set cur_code={6'h0, byte}.
      - If last, go to FLUSH; otherwise go to ACTIVE.
  - FLUSH: ready=0. Emit cur_code, go to EMPTY.
- next_code resets to 256. After writing code 16383, dict_full=1, and no further inserts or sync writes occur; compression continues using lookup only.
- A collision (slot valid, tag mismatch) is a miss. The resident entry is kept and nothing is inserted.
- The dictionary persists across frames. Only reset clears it, by re-entering INIT.
- Counters:
  - O_byte_cnt increments on each accepted byte.
  - O_code_cnt increments on each O_compress_data_en.
  - I_state_clr zeroes both counters and has priority over an increment in the same cycle.

## Timing
- All outputs are registered. Reset values:
  - O_payload_ready=0 (INIT)
  - O_compress_data=0, O_compress_data_en=0
  - O_dictionary_sync_data=0, O_dictionary_sync_addr=0, O_dictionary_sync_wren=0
  - O_byte_cnt=0, O_code_cnt=0
- INIT lasts 16384 cycles after reset deasserts. Ready rises on the following cycle.
- A byte accepted at edge N in ACTIVE is evaluated in CMP during cycle N+1. Its code and sync write are visible during cycle N+2. The code and sync write are coincident.
- Steady-state throughput is one byte per 2 cycles. Ready deasserts during CMP and FLUSH. Bytes presented while ready=0 are not taken; the source holds them.
- A sync write for a code always precedes any emitted code equal to that code.
- Reset mid-frame aborts the current string without emitting it, clears all state, and restarts INIT.

## Test plan
- Reset then idle: ready=0 for exactly 16384 cycles, then 1; all outputs 0 during INIT.
- Bytes 61,62,61,62,61,62,61 with last on the 7th byte:
  - Codes: 0x061, 0x062, 0x100, 0x102.
  - Sync writes: 256/0x406162, 257/0x406261, 258/0x410061.
  - O_byte_cnt=7, O_code_cnt=4.
- Single byte 0x41 with last in EMPTY: one code 0x041, no sync write, ready stays 1.
- Miss on the last byte (61,62+last): codes 0x061 then 0x062 on consecutive cycles (the second from FLUSH), plus sync write 256/0x406162.
- Dictionary fill: pseudo-random bytes until next_code passes 16383. There must be exactly 16128 sync writes in total, none after the last one at addr 16383. The output is then checked against a software model using the same hash and collision rules.
- Reset asserted mid-frame, then the first frame re-sent: after INIT, output is identical to a clean run.
- I_state_clr pulsed coincident with a code emission: both counters read 0 on the next cycle.
